// File: rtl/md5_rounds_49_to_64.sv
// MD5 rounds 49-64 (round group four, boolean function I).
//
// The sixteen steps are one combinational chain from (a_in, b_in, c_in, d_in)
// and the message block to the post-step-64 state, which is captured in an
// output register: one-cycle latency, one block per cycle.
// The chaining-value feed-forward addition is left to the caller.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears all outputs
//   in_valid   inputs are valid this cycle
//   a_in..d_in 32-bit chaining state entering step 49
//   message    512-bit block, word M[k] = message[32k+31:32k]
//   a_out..d_out  state after step 64 (held while in_valid is low)
//   out_valid  high for one cycle for every accepted block
module md5_rounds_49_to_64 (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] message,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic         out_valid
);

  localparam logic [31:0] K [16] = '{
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Message word used by each step: 7*i mod 16.
  localparam logic [3:0] G [16] = '{
    4'd0, 4'd7, 4'd14, 4'd5, 4'd12, 4'd3, 4'd10, 4'd1,
    4'd8, 4'd15, 4'd6, 4'd13, 4'd4, 4'd11, 4'd2, 4'd9
  };

  localparam logic [4:0] S [4] = '{5'd6, 5'd10, 5'd15, 5'd21};

  logic [31:0]  m_word [16];
  logic [127:0] step_out;

  for (genvar k = 0; k < 16; k++) begin : g_unpack
    assign m_word[k] = message[32*k +: 32];
  end

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
    return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
  endfunction

  always_comb begin
    logic [31:0] sa, sb, sc, sd, f, t;
    sa = a_in;
    sb = b_in;
    sc = c_in;
    sd = d_in;
    f  = '0;
    t  = '0;
    for (int i = 0; i < 16; i++) begin
      f  = sc ^ (sb | ~sd);
      t  = sa + f + K[i] + m_word[G[i]];
      sa = sd;
      sd = sc;
      sc = sb;
      sb = sb + rotl32(t, S[i % 4]);
    end
    step_out = {sa, sb, sc, sd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {a_out, b_out, c_out, d_out} <= step_out;
      end
    end
  end

endmodule

// File: tb/tb_md5_rounds_49_to_64.sv
module tb_md5_rounds_49_to_64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] message;
  logic [31:0]  a_out, b_out, c_out, d_out;
  logic         out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  md5_rounds_49_to_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .d_in      (d_in),
    .message   (message),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %032h want %032h", tag, got, want);
    end
  endtask

  // Reference MD5 steps 49..64 written in the classic software form.
  function automatic logic [127:0] golden(input logic [31:0] a0, b0, c0, d0,
                                          input logic [511:0] msg);
    logic [31:0] kt [16];
    logic [31:0] a, b, c, d, f, t, w, tmp;
    logic [63:0] dbl;
    int g, sh;
    kt = '{32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
           32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
           32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
           32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    a = a0; b = b0; c = c0; d = d0;
    for (int i = 0; i < 16; i++) begin
      g = (7 * i) % 16;
      case (i % 4)
        0: sh = 6;
        1: sh = 10;
        2: sh = 15;
        default: sh = 21;
      endcase
      w   = msg[g*32 +: 32];
      f   = c ^ (b | ~d);
      t   = a + f + kt[i] + w;
      dbl = {t, t} >> (32 - sh);
      tmp = d;
      d   = c;
      c   = b;
      b   = b + dbl[31:0];
      a   = tmp;
    end
    return {a, b, c, d};
  endfunction

  task automatic drive(input logic [31:0] a, b, c, d, input logic [511:0] msg);
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; d_in = d;
    message  = msg;
    in_valid = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [127:0] want);
    @(posedge clk);
    #1;
    check({tag, " valid"}, {127'd0, out_valid}, 128'd1);
    check({tag, " data"}, {a_out, b_out, c_out, d_out}, want);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [511:0] msg_kv, msg_oh, msg_r [3];
  logic [127:0] st_r [3];
  logic [127:0] exp_v, last_v;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a_in = 32'hdeadbeef; b_in = 32'h12345678; c_in = 32'h0badf00d; d_in = 32'hcafef00d;
    message = {16{32'h5a5aa5a5}};
    repeat (2) @(posedge clk);
    #1;
    check("reset data", {a_out, b_out, c_out, d_out}, 128'd0);
    check("reset valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Known vector
    msg_kv = {32'h00000000, 32'h000001b8, 32'h80676f6c, 32'h69726576,
              32'h206e6920, 32'h6e6f6974, 32'h61746e65, 32'h6d656c70,
              32'h6d692035, 32'h6d207369, 32'h444d2079, 32'h20736968,
              32'h54202138, 32'h30384d50, 32'h4e45206f, 32'h6c6c6548};
    drive(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, msg_kv);
    expect_out("known", golden(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, msg_kv));
    go_idle();
    @(posedge clk); #1;
    check("known drop valid", {127'd0, out_valid}, 128'd0);

    // All zero
    drive('0, '0, '0, '0, '0);
    expect_out("zero", golden('0, '0, '0, '0, '0));
    go_idle();

    // One-hot message words
    for (int k = 0; k < 16; k++) begin
      msg_oh = '0;
      msg_oh[32*k] = 1'b1;
      drive('0, '0, '0, '0, msg_oh);
      expect_out($sformatf("onehot m%0d", k), golden('0, '0, '0, '0, msg_oh));
    end
    go_idle();

    // Back-to-back random blocks
    for (int j = 0; j < 3; j++) begin
      st_r[j] = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < 16; w++) msg_r[j][32*w +: 32] = $urandom;
    end
    for (int j = 0; j < 3; j++) begin
      drive(st_r[j][127:96], st_r[j][95:64], st_r[j][63:32], st_r[j][31:0], msg_r[j]);
      expect_out($sformatf("b2b %0d", j),
                 golden(st_r[j][127:96], st_r[j][95:64], st_r[j][63:32], st_r[j][31:0], msg_r[j]));
    end
    last_v = golden(st_r[2][127:96], st_r[2][95:64], st_r[2][63:32], st_r[2][31:0], msg_r[2]);
    go_idle();
    a_in = 32'h11111111;
    message = {16{32'h22222222}};
    @(posedge clk); #1;
    check("b2b idle valid", {127'd0, out_valid}, 128'd0);
    check("b2b idle hold", {a_out, b_out, c_out, d_out}, last_v);
    @(posedge clk); #1;
    check("b2b idle hold2", {a_out, b_out, c_out, d_out}, last_v);

    // Wrap-around
    drive('1, '1, '1, '1, '1);
    expect_out("ones", golden('1, '1, '1, '1, '1));

    // Mid-stream reset: clears without a clock edge, discards the in-flight block
    exp_v = golden(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, msg_kv);
    drive(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, msg_kv);
    expect_out("pre-rst", exp_v);
    #1;
    rst = 1'b1;
    #1;
    check("async rst data", {a_out, b_out, c_out, d_out}, 128'd0);
    check("async rst valid", {127'd0, out_valid}, 128'd0);
    @(posedge clk); #1;
    check("rst hold data", {a_out, b_out, c_out, d_out}, 128'd0);
    check("rst hold valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_out("post-rst", exp_v);
    go_idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md5_rounds_49_to_64.md
Name: md5_rounds_49_to_64

Overview:
- Computes MD5 rounds 49–64 (fourth round group, function I) on a 128-bit chaining state (a, b, c, d) and one 512-bit message block.
- The 16 steps are a single combinational chain; the result is captured in an output register, giving 1-cycle latency.
- Sits after the rounds-33-to-48 stage in the MD5 compression datapath. Its outputs are the post-round-64 state, before the final chaining-value addition (done by the caller).

Parameters:
- none

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  inputs valid this cycle
- a_in  input  32  state word A
- b_in  input  32  state word B
- c_in  input  32  state word C
- d_in  input  32  state word D
- message  input  512  block; word k (little-endian MD5 word M[k]) = message[32k+31:32k], M[0] in bits 31:0, M[15] in bits 511:480
- a_out  output  32  A after step 64
- b_out  output  32  B after step 64
- c_out  output  32  C after step 64
- d_out  output  32  D after step 64
- out_valid  output  1  outputs hold a new result

Behaviour:
- Reset (async, rst=1): a_out, b_out, c_out, d_out = 0; out_valid = 0. These hold while rst is high. The first capture is at the first rising clk after rst deasserts.
- Each step i = 0..15 (MD5 step 49+i), starting from A=a_in, B=b_in, C=c_in, D=d_in:
  - F = C xor (B or not D)
  - T = A + F + K[i] + M[g[i]], modulo 2^32
  - newB = B + rotl32(T, s[i]), modulo 2^32
  - (A, B, C, D) <= (D, newB, B, C)
- K[0..15] = f4292244, 432aff97, ab9423a7, fc93a039, 655b59c3, 8f0ccc92, ffeff47d, 85845dd1, 6fa87e4f, fe2ce6e0, a3014314, 4e0811a1, f7537e82, bd3af235, 2ad7d2bb, eb86d391 (hex).
- s[i] cycles 6, 10, 15, 21.
- g[i] = 7i mod 16, i.e. 0, 7, 14, 5, 12, 3, 10, 1, 8, 15, 6, 13, 4, 11, 2, 9.
- All additions wrap modulo 2^32. No saturation and no carry out.
- Rising clk with in_valid=1: the step-16 (A, B, C, D) is registered into a_out..d_out, and out_valid <= 1.
- Rising clk with in_valid=0: data outputs hold their previous values; out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one block per cycle, and back-to-back in_valid is supported.
- There is no backpressure; the consumer must sample out_valid every cycle.
- No output state is added to the inputs. The feed-forward (a_out + a_in_original, etc.) is external.
- rst asserted mid-stream: outputs clear immediately and the in-flight result is discarded.

Test Plan:
1. Reset: assert rst with arbitrary inputs -> all outputs 0, out_valid 0, asynchronously and without a clock edge.
2. Known vector:
   - Inputs: a=67452301, b=efcdab89, c=98badcfe, d=10325476.
   - M[0..15] = 6c6c6548, 4e45206f, 30384d50, 54202138, 20736968, 6d207369, 444d2079, 6d692035, 6d656c70, 61746e65, 6e6f6974, 206e6920, 69726576, 80676f6c, 000001b8, 00000000.
   - Pulse in_valid -> one cycle later out_valid=1, and outputs equal the bit-exact software golden model of steps 49–64.
3. All-zero state and message: in_valid=1 -> outputs match the golden model. This exercises the constant and rotate path only, since M=0.
4. Message-index check: single-word one-hot patterns, M[k]=00000001 for each k=0..15 with all other words and the state zero -> each result matches the model. This catches any g[i] or word-packing mismatch.
5. Back-to-back: three different random blocks on consecutive cycles -> three consecutive out_valid=1 results, each matching its own input. After in_valid drops, out_valid=0 and the outputs hold the last result.
6. Wrap-around: state and message all ffffffff -> matches the model. This verifies modulo-2^32 addition.
